store_buffer: RTL and testbench



---
 rtl/risc24_mem_pkg.sv | 18 +
 rtl/sb_fifo.sv | 70 +++++++
 rtl/store_buffer.sv | 119 +++++++++++
 tb/tb_store_buffer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc24_mem_pkg.sv
// rtl/risc24_mem_pkg.sv - shared widths, FSM states and store entry type for the store buffer
package risc24_mem_pkg;

  localparam int SB_AW = 16;
  localparam int SB_DW = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    READ  = 2'd2
  } sb_state_t;

  typedef struct packed {
    logic [SB_AW-1:0] adr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/sb_fifo.sv
// rtl/sb_fifo.sv - store entry FIFO with youngest-match address lookup
module sb_fifo
  import risc24_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  sb_entry_t        push_entry,
  input  logic             pop,
  input  logic [SB_AW-1:0] lookup_adr,
  output sb_entry_t        head,
  output logic             hit,
  output logic [SB_DW-1:0] hit_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  sb_entry_t      entries [DEPTH];
  logic [PW-1:0]  head_ptr;
  logic [PW-1:0]  tail_ptr;
  logic [PW:0]    count;
  logic [PW-1:0]  idx;

  assign head  = entries[head_ptr];
  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);

  // Entry storage needs no reset: validity comes from head/count only.
  always_ff @(posedge clk) begin
    if (push) begin
      entries[tail_ptr] <= push_entry;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks simultaneous push and pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + 1'b1;
      if (pop)  head_ptr <= head_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest store.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_ptr + PW'(i);
      if (((PW+1)'(i) < count) && (entries[idx].adr == lookup_adr)) begin
        hit      = 1'b1;
        hit_data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write buffer with load forwarding between core and data memory
module store_buffer
  import risc24_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] adr,
  input  logic [DW-1:0] writedata,
  input  logic          memwrite,
  input  logic          memread,
  output logic [DW-1:0] readdata,
  output logic          stall,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          empty,
  output logic          full
);

  sb_state_t     state;
  sb_state_t     state_nxt;
  logic          pend_valid;
  logic [AW-1:0] pend_adr;
  sb_entry_t     push_entry;
  sb_entry_t     head;
  logic          hit;
  logic [DW-1:0] hit_data;
  logic          push;
  logic          pop;
  logic          load;
  logic          load_hit;
  logic          load_miss;
  logic          read_done;

  // A store beats a load in the same cycle; a load is ignored while a miss is outstanding.
  assign push       = memwrite & ~full;
  assign load       = memread & ~memwrite & ~pend_valid;
  assign load_hit   = load & hit;
  assign load_miss  = load & ~hit;
  assign read_done  = (state == READ) & mem_ack;
  assign pop        = (state == DRAIN) & mem_ack;
  assign stall      = (memwrite & full) | (pend_valid & ~read_done);
  assign push_entry = '{adr: adr, data: writedata};

  sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .lookup_adr (adr),
    .head       (head),
    .hit        (hit),
    .hit_data   (hit_data),
    .full       (full),
    .empty      (empty)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and memory port drive; a new miss or push is seen in IDLE the same cycle.
  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_adr   = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        if (pend_valid | load_miss)  state_nxt = READ;
        else if (~empty | push)      state_nxt = DRAIN;
      end
      DRAIN: begin
        mem_we    = 1'b1;
        mem_adr   = head.adr;
        mem_wdata = head.data;
        if (mem_ack) state_nxt = IDLE;
      end
      READ: begin
        mem_re  = 1'b1;
        mem_adr = pend_adr;
        if (mem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pending miss register: set by a missing load, cleared by the read's ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_adr   <= '0;
    end else if (read_done) begin
      pend_valid <= 1'b0;
    end else if (load_miss) begin
      pend_valid <= 1'b1;
      pend_adr   <= adr;
    end
  end

  // Load result: forwarded data on a hit, memory data on the read ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         readdata <= '0;
    else if (read_done) readdata <= mem_rdata;
    else if (load_hit)  readdata <= hit_data;
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - self-checking bench for store_buffer
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] adr;
  logic [15:0] writedata;
  logic        memwrite;
  logic        memread;
  logic [15:0] readdata;
  logic        stall;
  logic [15:0] mem_adr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [15:0] mem_rdata = 16'h0;
  logic        mem_ack = 1'b0;
  logic        empty;
  logic        full;

  logic        ack_mode;
  logic        ack_force;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          n_stall_seen = 0;
  int          n_re_seen = 0;
  int          n_both = 0;

  logic [15:0] mem_model [logic [15:0]];
  logic [15:0] ref_mem   [logic [15:0]];

  store_buffer #(.DEPTH(4), .AW(16), .DW(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .adr       (adr),
    .writedata (writedata),
    .memwrite  (memwrite),
    .memread   (memread),
    .readdata  (readdata),
    .stall     (stall),
    .mem_adr   (mem_adr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .empty     (empty),
    .full      (full)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a == 16'h0030) ? 16'h1234 : (a ^ 16'hC3C3);
  endfunction

  function automatic logic [15:0] mem_read(input logic [15:0] a);
    return mem_model.exists(a) ? mem_model[a] : init_val(a);
  endfunction

  function automatic logic [15:0] ref_read(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  always @(posedge clk) begin
    #2;
    if (ack_mode) mem_ack = (mem_we || mem_re) && ($urandom_range(0, 2) == 0);
    else          mem_ack = ack_force;
    mem_rdata = mem_read(mem_adr);
  end

  always @(negedge clk) begin
    if (!reset && mem_we && mem_ack) mem_model[mem_adr] = mem_wdata;
    if (stall) n_stall_seen++;
    if (mem_re) n_re_seen++;
    if (mem_we && mem_re) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_store(input logic [15:0] a, input logic [15:0] d);
    int k = 0;
    adr = a; writedata = d; memwrite = 1'b1; memread = 1'b0;
    @(negedge clk);
    while (stall && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("store_accept", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    memwrite = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] a, output logic [15:0] d, output logic miss);
    int k = 0;
    adr = a; memread = 1'b1; memwrite = 1'b0;
    @(posedge clk); #1;
    memread = 1'b0;
    @(negedge clk);
    miss = stall | mem_re;
    if (miss) begin
      while (stall && k < 200) begin
        @(negedge clk);
        k++;
      end
      check("load_wait", {31'b0, stall}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
    end
    d = readdata;
    @(posedge clk); #1;
  endtask

  task automatic drain_all();
    int k = 0;
    ack_force = 1'b1;
    @(negedge clk);
    while (!empty && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("drain_empty", {31'b0, empty}, 32'd1);
    @(posedge clk); #1;
    ack_force = 1'b0;
  endtask

  initial begin
    logic [15:0] d;
    logic        miss;
    int          s0;
    int          r0;
    logic [15:0] a;

    reset = 1'b1; memwrite = 1'b0; memread = 1'b0; adr = '0; writedata = '0;
    ack_mode = 1'b0; ack_force = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_readdata", {16'b0, readdata}, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_mem_re", {31'b0, mem_re}, 32'd0);
    check("rst_mem_adr", {16'b0, mem_adr}, 32'd0);
    check("rst_mem_wdata", {16'b0, mem_wdata}, 32'd0);
    check("rst_empty", {31'b0, empty}, 32'd1);
    check("rst_full", {31'b0, full}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Store with memory always acknowledging.
    ack_force = 1'b1;
    do_store(16'h0004, 16'h0001);
    ref_mem[16'h0004] = 16'h0001;
    @(negedge clk);
    check("t1_mem_we", {31'b0, mem_we}, 32'd1);
    check("t1_mem_adr", {16'b0, mem_adr}, 32'h4);
    check("t1_mem_wdata", {16'b0, mem_wdata}, 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_empty", {31'b0, empty}, 32'd1);
    check("t1_we_low", {31'b0, mem_we}, 32'd0);
    @(posedge clk); #1;
    ack_force = 1'b0;

    // Fill the buffer, then a fifth store stalls until one entry drains.
    for (int i = 0; i < 4; i++) begin
      do_store(16'h0010 + 16'(i), 16'h0100 + 16'(i));
      ref_mem[16'h0010 + 16'(i)] = 16'h0100 + 16'(i);
    end
    adr = 16'h0014; writedata = 16'h0104; memwrite = 1'b1;
    @(negedge clk);
    check("t2_full", {31'b0, full}, 32'd1);
    check("t2_stall", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    ack_force = 1'b1;
    @(negedge clk);
    check("t2_stall_pop_cycle", {31'b0, stall}, 32'd1);
    check("t2_drain_adr", {16'b0, mem_adr}, 32'h10);
    @(posedge clk); #1;
    ack_force = 1'b0;
    @(negedge clk);
    check("t2_full_after_pop", {31'b0, full}, 32'd0);
    check("t2_stall_released", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    memwrite = 1'b0;
    ref_mem[16'h0014] = 16'h0104;
    @(negedge clk);
    check("t2_fifth_accepted", {31'b0, full}, 32'd1);
    @(posedge clk); #1;
    drain_all();

    // Two stores to one address, then a load forwards the younger one.
    s0 = n_stall_seen; r0 = n_re_seen;
    do_store(16'h0008, 16'hAAAA);
    do_store(16'h0008, 16'h5555);
    ref_mem[16'h0008] = 16'h5555;
    do_load(16'h0008, d, miss);
    check("t3_fwd_data", {16'b0, d}, 32'h5555);
    check("t3_hit", {31'b0, miss}, 32'd0);
    check("t3_no_stall", n_stall_seen - s0, 32'd0);
    check("t3_no_re", n_re_seen - r0, 32'd0);
    drain_all();

    // Load miss behind an in-progress drain.
    do_store(16'h0020, 16'hBEEF);
    ref_mem[16'h0020] = 16'hBEEF;
    adr = 16'h0030; memread = 1'b1;
    @(posedge clk); #1;
    memread = 1'b0;
    @(negedge clk);
    check("t4_stall", {31'b0, stall}, 32'd1);
    check("t4_drain_we", {31'b0, mem_we}, 32'd1);
    check("t4_drain_adr", {16'b0, mem_adr}, 32'h20);
    check("t4_no_re", {31'b0, mem_re}, 32'd0);
    @(posedge clk); #1;
    ack_force = 1'b1;
    @(negedge clk);
    check("t4_stall_in_drain_ack", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    ack_force = 1'b0;
    @(negedge clk);
    check("t4_idle_we", {31'b0, mem_we}, 32'd0);
    check("t4_idle_stall", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("t4_read_re", {31'b0, mem_re}, 32'd1);
    check("t4_read_adr", {16'b0, mem_adr}, 32'h30);
    @(posedge clk); #1;
    ack_force = 1'b1;
    @(negedge clk);
    check("t4_stall_ack_cycle", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    ack_force = 1'b0;
    @(negedge clk);
    check("t4_readdata", {16'b0, readdata}, 32'h1234);
    check("t4_re_done", {31'b0, mem_re}, 32'd0);
    @(posedge clk); #1;

    // Reset while draining discards queued stores.
    do_store(16'h0040, 16'h1111);
    do_store(16'h0041, 16'h2222);
    do_store(16'h0042, 16'h3333);
    @(negedge clk);
    check("t5_we_before", {31'b0, mem_we}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("t5_we_async", {31'b0, mem_we}, 32'd0);
    check("t5_empty_async", {31'b0, empty}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    ack_mode = 1'b1;
    do_load(16'h0040, d, miss);
    check("t5_miss", {31'b0, miss}, 32'd1);
    check("t5_data", {16'b0, d}, {16'b0, init_val(16'h0040)});

    // Random store/load mix against the last-written-value model.
    for (int n = 0; n < 80; n++) begin
      a = 16'($urandom_range(0, 7));
      if ($urandom_range(0, 9) < 6) begin
        d = 16'($urandom_range(0, 16'hFFFF));
        do_store(a, d);
        ref_mem[a] = d;
      end else begin
        do_load(a, d, miss);
        check("rand_load", {16'b0, d}, {16'b0, ref_read(a)});
      end
    end
    for (int n = 0; n < 8; n++) begin
      do_load(16'(n), d, miss);
      check("final_load", {16'b0, d}, {16'b0, ref_read(16'(n))});
    end
    check("we_re_exclusive", n_both, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
